dff_clr_pre: RTL and testbench



---
 rtl/dff_clr_pre_pkg.sv | 28 ++
 rtl/dff_clr_pre_bit.sv | 40 ++++
 rtl/dff_clr_pre.sv | 58 +++++
 tb/tb_dff_clr_pre.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/dff_clr_pre_pkg.sv
// dff_clr_pre_pkg
// Shared constants and types for the dff_clr_pre register bank.
//   DFF_INIT_ZERO : one-bit default for the INIT value. Replicate it to WIDTH.
//   prio_e        : per-bit priority of the actions that can change Q, highest first.
//   prio_of()     : names which action controls a bit for a given set of
//                   control levels. Assertions and benches use it.
package dff_clr_pre_pkg;

  localparam logic DFF_INIT_ZERO = 1'b0;

  // Per-bit priority, highest first: clear, preset, synchronous reset, data load.
  typedef enum logic [1:0] {
    PRIO_CLR = 2'd0,
    PRIO_PRE = 2'd1,
    PRIO_RST = 2'd2,
    PRIO_D   = 2'd3
  } prio_e;

  function automatic prio_e prio_of(input logic clr, input logic pre, input logic rst);
    prio_e p;
    p = PRIO_D;
    if (clr)      p = PRIO_CLR;
    else if (pre) p = PRIO_PRE;
    else if (rst) p = PRIO_RST;
    return p;
  endfunction

endpackage

// File: rtl/dff_clr_pre_bit.sv
// dff_clr_pre_bit
// One flop with an asynchronous clear, an asynchronous preset, a synchronous
// reset to INIT_BIT, and a clock enable.
// Ports:
//   C   : clock, active on the rising edge. It may be tied to 0.
//   RST : synchronous reset, active-high. It loads INIT_BIT.
//   CE  : clock enable. When it is 0, RST and D are ignored at an edge.
//   D   : data input.
//   CLR : asynchronous clear, active-high. It has the highest priority.
//   PRE : asynchronous preset, active-high. CLR overrides it.
//   Q   : registered output.
module dff_clr_pre_bit
  import dff_clr_pre_pkg::*;
#(
  parameter logic INIT_BIT = DFF_INIT_ZERO
) (
  input  logic C,
  input  logic RST,
  input  logic CE,
  input  logic D,
  input  logic CLR,
  input  logic PRE,
  output logic Q
);

  // The preset is gated by the clear. This gives the flop an async-set event
  // when CLR drops while PRE is still high, so Q rises to 1 at once instead of
  // waiting for a clock edge.
  logic set_q;
  assign set_q = PRE & ~CLR;

  // The synchronous reset is muxed into the data path. While CLR or PRE is
  // active, the async branches hold Q, so D can never appear on Q.
  always_ff @(posedge C or posedge CLR or posedge set_q) begin
    if (CLR)        Q <= 1'b0;
    else if (set_q) Q <= 1'b1;
    else if (CE)    Q <= RST ? INIT_BIT : D;
  end

endmodule

// File: rtl/dff_clr_pre.sv
// dff_clr_pre
// A bank of WIDTH independent D flops. Each flop has its own asynchronous clear
// and preset, and all flops share a synchronous reset to INIT.
// The bank can serve as a plain register, as a request flag (D=0, PRE sets the
// flag), or as a set/reset latch (C tied to 0).
// Ports:
//   C   : clock, active on the rising edge.
//   RST : synchronous reset, active-high. It loads INIT.
//   CE  : clock enable. This port exists only when DFF_CLR_PRE_CE_EN is defined.
//         Without it, the bank behaves as if CE were 1.
//   D   [WIDTH-1:0] : data input.
//   CLR [WIDTH-1:0] : per-bit asynchronous clear. Clear beats preset.
//   PRE [WIDTH-1:0] : per-bit asynchronous preset.
//   Q   [WIDTH-1:0] : registered output.
// Optional feature macro: DFF_CLR_PRE_CE_EN.
module dff_clr_pre
  import dff_clr_pre_pkg::*;
#(
  parameter int               WIDTH = 1,
  parameter logic [WIDTH-1:0] INIT  = {WIDTH{DFF_INIT_ZERO}}
) (
  input  logic             C,
  input  logic             RST,
`ifdef DFF_CLR_PRE_CE_EN
  input  logic             CE,
`endif
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] CLR,
  input  logic [WIDTH-1:0] PRE,
  output logic [WIDTH-1:0] Q
);

  if (WIDTH < 1) begin : g_width_check
    $error("dff_clr_pre: WIDTH must be at least 1");
  end

  logic ce_int;
`ifdef DFF_CLR_PRE_CE_EN
  assign ce_int = CE;
`else
  assign ce_int = 1'b1;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_clr_pre_bit #(
      .INIT_BIT (INIT[i])
    ) u_bit (
      .C   (C),
      .RST (RST),
      .CE  (ce_int),
      .D   (D[i]),
      .CLR (CLR[i]),
      .PRE (PRE[i]),
      .Q   (Q[i])
    );
  end

endmodule

// File: tb/tb_dff_clr_pre.sv
// tb_dff_clr_pre
// Directed bench for dff_clr_pre. It uses a 4-bit clocked bank with INIT=1010
// and a 1-bit bank whose clock is tied to 0, so that bank acts as a latch.
module tb_dff_clr_pre;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       ce  = 1'b1;
  logic [3:0] d   = '0;
  logic [3:0] clr = '0;
  logic [3:0] pre = '0;
  logic [3:0] q;

  logic       l_rst = 1'b0;
  logic       l_ce  = 1'b1;
  logic [0:0] l_d   = '0;
  logic [0:0] l_clr = '0;
  logic [0:0] l_pre = '0;
  logic [0:0] l_q;

  int n_checks = 0;
  int n_pass   = 0;

  dff_clr_pre #(.WIDTH(4), .INIT(4'b1010)) u_dut (
    .C   (clk),
    .RST (rst),
`ifdef DFF_CLR_PRE_CE_EN
    .CE  (ce),
`endif
    .D   (d),
    .CLR (clr),
    .PRE (pre),
    .Q   (q)
  );

  dff_clr_pre #(.WIDTH(1), .INIT(1'b0)) u_latch (
    .C   (1'b0),
    .RST (l_rst),
`ifdef DFF_CLR_PRE_CE_EN
    .CE  (l_ce),
`endif
    .D   (l_d),
    .CLR (l_clr),
    .PRE (l_pre),
    .Q   (l_q)
  );

  // ---------------- driver tasks ----------------
  // Wait for the next rising edge, then settle 2 ns past it. The next edge is
  // 8 ns away, so async pulses fit before it.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  logic [3:0] vec_q[$];

  initial begin
    // Reset and load
    rst = 1'b1; step();
    check("reset_init", q, 4'b1010);
    rst = 1'b0; d = 4'b0101; step();
    check("load_d", q, 4'b0101);

    // Async priority, no clock edge involved
    d = 4'b1111;
    clr = 4'b0001; pre = 4'b0011; #1;
    check("async_prio", q, 4'b0110);
    clr = 4'b0000; pre = 4'b0000; #1;
    check("async_release_hold", q, 4'b0110);
    clr = 4'b0001; pre = 4'b0001; #1;
    check("clr_beats_pre", q, 4'b0110);
    clr = 4'b0000; #1;
    check("clr_release_pre_high", q, 4'b0111);
    pre = 4'b0000; #1;
    check("pre_release_hold", q, 4'b0111);
    step();
    check("load_after_async", q, 4'b1111);

    // Request flag: load 0, preset sets the flag
    d = 4'b0000; step();
    check("flag_cleared", q, 4'b0000);
    pre = 4'b0100; #1;
    check("flag_set", q, 4'b0100);
    pre = 4'b0000; #1;
    check("flag_hold", q, 4'b0100);
    step();
    check("flag_edge_clear", q, 4'b0000);
    pre = 4'b0100; step();
    check("pre_across_edge", q, 4'b0100);
    pre = 4'b0000;

    // RST vs PRE
    pre = 4'b0001; rst = 1'b1; step();
    check("rst_with_pre", q, 4'b1011);
    pre = 4'b0000; #1;
    check("rst_pre_drop_hold", q, 4'b1011);
    step();
    check("rst_next_edge", q, 4'b1010);

    // CLR held across an edge: D must not appear on Q
    rst = 1'b0; clr = 4'b1111; #1;
    check("clr_all", q, 4'b0000);
    d = 4'b1111; step();
    check("clr_blocks_d", q, 4'b0000);
    clr = 4'b0000; #1;
    check("clr_release_hold", q, 4'b0000);

    // Plain register vectors
    vec_q.push_back(4'b0011);
    vec_q.push_back(4'b1100);
    vec_q.push_back(4'b1001);
    foreach (vec_q[i]) begin
      d = vec_q[i]; step();
      check("vector_load", q, vec_q[i]);
    end

`ifdef DFF_CLR_PRE_CE_EN
    // Clock enable
    ce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = ~d; step();
      check("ce_hold", q, 4'b1001);
    end
    clr = 4'b1111; #1;
    check("ce_off_clr", q, 4'b0000);
    clr = 4'b0000; rst = 1'b1; step();
    check("ce_off_rst", q, 4'b0000);
    ce = 1'b1; step();
    check("ce_on_rst", q, 4'b1010);
    rst = 1'b0;
    l_ce = 1'b0;
`endif

    // Latch mode (C tied low)
    l_pre = 1'b1; #1;
    check("latch_pre", {3'b000, l_q}, 4'b0001);
    l_pre = 1'b0; #1;
    check("latch_pre_hold", {3'b000, l_q}, 4'b0001);
    l_clr = 1'b1; #1;
    check("latch_clr", {3'b000, l_q}, 4'b0000);
    l_clr = 1'b0; #1;
    check("latch_clr_hold", {3'b000, l_q}, 4'b0000);
    l_pre = 1'b1; #1; l_pre = 1'b0; #1;
    l_rst = 1'b1; l_d = 1'b0; #20;
    check("latch_rst_no_effect", {3'b000, l_q}, 4'b0001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
